// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants for the LCD character input path
package lcd_pkg;
    localparam int LCD_DATA_W          = 8;
    localparam int LCD_DEBOUNCE_CYCLES = 1024;
    localparam int LCD_QUEUE_DEPTH     = 8;
endpackage

// File: rtl/lcd_char_queue_if.sv
// rtl/lcd_char_queue_if.sv - valid/ready character stream towards the write sequencer
interface lcd_char_queue_if
    import lcd_pkg::*;
#(
    parameter int DATA_W = LCD_DATA_W
) ();
    logic              char_valid;
    logic              char_ready;
    logic [DATA_W-1:0] char_data;

    modport master (output char_valid, output char_data, input char_ready);
    modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/lcd_char_queue_btn_debounce.sv
// rtl/lcd_char_queue_btn_debounce.sv - button synchroniser, debounce filter and press pulse
module btn_debounce
    import lcd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = LCD_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    input  logic debounce_en,
    output logic push
);
    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1, s2, deb, deb_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= button;
            s2    <= s1;
            deb_q <= deb;
            // Bypass tracks s2 directly, equivalent to a one-cycle filter
            if (!debounce_en) begin
                deb <= s2;
                cnt <= '0;
            end else if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= ~deb;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign push = deb & ~deb_q;
endmodule

// File: rtl/lcd_char_queue.sv
// rtl/lcd_char_queue.sv - debounced button capture feeding a character FIFO
module lcd_char_queue
    import lcd_pkg::*;
#(
    parameter int DATA_W          = LCD_DATA_W,
    parameter int FIFO_DEPTH      = LCD_QUEUE_DEPTH,
    parameter int DEBOUNCE_CYCLES = LCD_DEBOUNCE_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          button,
    input  logic [DATA_W-1:0]             data_btn,
    input  logic                          debounce_en,
    lcd_char_queue_if.master              char_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              push, pop, full, do_push;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .button      (button),
        .debounce_en (debounce_en),
        .push        (push)
    );

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = char_if.char_valid & char_if.char_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_btn;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push & full & ~pop) overflow <= 1'b1;
        end
    end

    assign fifo_count         = count;
    assign char_if.char_valid = (count != '0);
    // Gated so stale memory never shows while empty
    assign char_if.char_data  = char_if.char_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_lcd_char_queue.sv
// tb/tb_lcd_char_queue.sv - directed self-checking bench for lcd_char_queue
module tb_lcd_char_queue;
    import lcd_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       button = 1'b0;
    logic [7:0] data_btn = 8'h00;
    logic       debounce_en = 1'b0;
    logic [3:0] fifo_count;
    logic       overflow;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    lcd_char_queue_if #(.DATA_W(8)) cif ();

    lcd_char_queue #(.DATA_W(8), .FIFO_DEPTH(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .button      (button),
        .data_btn    (data_btn),
        .debounce_en (debounce_en),
        .char_if     (cif),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bypass-mode press: push lands on the 4th edge after button goes high
    task automatic press(input logic [7:0] d, input logic pop_at_push);
        data_btn = d;
        button   = 1'b1;
        step(); step(); step();
        if (pop_at_push) cif.char_ready = 1'b1;
        step();
        cif.char_ready = 1'b0;
        button = 1'b0;
        step(); step(); step(); step();
    endtask

    task automatic test_reset();
        total_cnt++;
        if (cif.char_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0 || cif.char_data !== 8'h00)
            $display("FAIL reset_state: valid=%b count=%0d ovf=%b data=%h, want 0/0/0/00",
                     cif.char_valid, fifo_count, overflow, cif.char_data);
        else pass_cnt++;
    endtask

    task automatic test_bypass_press();
        debounce_en = 1'b0;
        data_btn    = 8'h41;
        button      = 1'b1;
        step(); step(); step();
        total_cnt++;
        if (fifo_count !== 4'd0) $display("FAIL bypass_early: count=%0d want 0", fifo_count);
        else pass_cnt++;
        step();
        total_cnt++;
        if (cif.char_valid !== 1'b1 || cif.char_data !== 8'h41 || fifo_count !== 4'd1)
            $display("FAIL bypass_push: valid=%b data=%h count=%0d want 1/41/1",
                     cif.char_valid, cif.char_data, fifo_count);
        else pass_cnt++;
        cif.char_ready = 1'b1;
        step();
        cif.char_ready = 1'b0;
        total_cnt++;
        if (fifo_count !== 4'd0 || cif.char_valid !== 1'b0)
            $display("FAIL bypass_pop: count=%0d valid=%b want 0/0", fifo_count, cif.char_valid);
        else pass_cnt++;
        button = 1'b0;
        step(); step(); step(); step();
    endtask

    task automatic test_bounce();
        debounce_en = 1'b1;
        data_btn    = 8'h5a;
        repeat (2) begin
            button = 1'b1;
            step(); step(); step();
            button = 1'b0;
            step(); step();
        end
        button = 1'b1;
        for (int e = 1; e <= 6; e++) step();
        total_cnt++;
        if (fifo_count !== 4'd0) $display("FAIL bounce_glitch: count=%0d after edge 6, want 0", fifo_count);
        else pass_cnt++;
        step();
        total_cnt++;
        if (fifo_count !== 4'd1 || cif.char_data !== 8'h5a)
            $display("FAIL bounce_push: count=%0d data=%h after edge 7, want 1/5a", fifo_count, cif.char_data);
        else pass_cnt++;
        repeat (5) step();
        button = 1'b0;
        repeat (10) step();
        total_cnt++;
        if (fifo_count !== 4'd1) $display("FAIL bounce_single: count=%0d want 1", fifo_count);
        else pass_cnt++;
        cif.char_ready = 1'b1;
        step();
        cif.char_ready = 1'b0;
        debounce_en = 1'b0;
        step(); step();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) press(8'h30 + 8'(i), 1'b0);
        total_cnt++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1)
            $display("FAIL overflow_set: count=%0d ovf=%b want 8/1", fifo_count, overflow);
        else pass_cnt++;
        cif.char_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (cif.char_data !== 8'h30 + 8'(i) || cif.char_valid !== 1'b1)
                $display("FAIL overflow_drain[%0d]: data=%h valid=%b want %h/1",
                         i, cif.char_data, cif.char_valid, 8'h30 + 8'(i));
            else pass_cnt++;
            step();
        end
        cif.char_ready = 1'b0;
        total_cnt++;
        if (cif.char_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b1)
            $display("FAIL overflow_empty: valid=%b count=%0d ovf=%b want 0/0/1",
                     cif.char_valid, fifo_count, overflow);
        else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 8; i++) press(8'h50 + 8'(i), 1'b0);
        press(8'h58, 1'b1);
        total_cnt++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0)
            $display("FAIL full_push_pop: count=%0d ovf=%b want 8/0", fifo_count, overflow);
        else pass_cnt++;
        cif.char_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (cif.char_data !== 8'h51 + 8'(i))
                $display("FAIL full_drain[%0d]: data=%h want %h", i, cif.char_data, 8'h51 + 8'(i));
            else pass_cnt++;
            step();
        end
        cif.char_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [3:0] max_cnt;
        logic [7:0] d;
        max_cnt = 4'd0;
        for (int i = 0; i < 20; i++) begin
            d = 8'h61 + 8'(i);
            press(d, 1'b0);
            if (fifo_count > max_cnt) max_cnt = fifo_count;
            total_cnt++;
            if (cif.char_data !== d || fifo_count !== 4'd1)
                $display("FAIL wrap[%0d]: data=%h count=%0d want %h/1", i, cif.char_data, fifo_count, d);
            else pass_cnt++;
            cif.char_ready = 1'b1;
            step();
            cif.char_ready = 1'b0;
        end
        total_cnt++;
        if (max_cnt !== 4'd1 || fifo_count !== 4'd0)
            $display("FAIL wrap_max: max=%0d final=%0d want 1/0", max_cnt, fifo_count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        press(8'h71, 1'b0);
        press(8'h72, 1'b0);
        press(8'h73, 1'b0);
        total_cnt++;
        if (fifo_count !== 4'd3) $display("FAIL reset_mid_fill: count=%0d want 3", fifo_count);
        else pass_cnt++;
        #1 reset = 1'b1;
        #1;
        total_cnt++;
        if (cif.char_valid !== 1'b0 || cif.char_data !== 8'h00 || fifo_count !== 4'd0 || overflow !== 1'b0)
            $display("FAIL reset_mid: valid=%b data=%h count=%0d ovf=%b want 0/00/0/0",
                     cif.char_valid, cif.char_data, fifo_count, overflow);
        else pass_cnt++;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        cif.char_ready = 1'b0;
        step(); step();
        test_reset();
        reset = 1'b0;
        step();
        test_bypass_press();
        test_bounce();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/lcd_char_queue.md
Name: lcd_char_queue

Overview:
Upstream input stage for the LCD write path. It synchronises and debounces the user write button, captures the 8-bit switch character on each debounced press, and buffers the characters in a small FIFO. It presents them to the ASCII write sequencer over a valid/ready handshake, so presses made while the LCD is busy are not lost. It runs on the divided LCD clock, in the same domain as the write sequencer.

Parameters:
DATA_W, 8, character width in bits (LCD data bus width)
FIFO_DEPTH, 8, number of queued characters; power of 2, >= 2
DEBOUNCE_CYCLES, 1024, consecutive stable cycles required before the debounced level changes; >= 1

Ports:
clk  in  1  divided LCD clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
button  in  1  raw push-button input, asynchronous to clk
data_btn  in  DATA_W  switch character; must be stable around the press
debounce_en  in  1  1 = debounce filter active; 0 = filter bypassed
char_ready  in  1  write sequencer can accept a character this cycle
char_valid  out  1  queue is non-empty; char_data is valid
char_data  out  DATA_W  head-of-queue character
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of characters currently queued
overflow  out  1  sticky flag; a press was dropped because the queue was full

Behaviour:
- Reset is asynchronous and active-high. On assertion, all of the following clear immediately: sync flops, debounced level, debounce counter, read/write pointers, count and overflow. Outputs read char_valid=0, char_data=0, fifo_count=0, overflow=0. FIFO memory contents are don't-care.
- Synchroniser: two-flop chain button -> s1 -> s2.
- Debounce, debounce_en=1:
  - cnt (width $clog2(DEBOUNCE_CYCLES)+1) resets to 0 on any edge where s2 == deb.
  - On an edge where s2 != deb: if cnt == DEBOUNCE_CYCLES-1, toggle deb and clear cnt; otherwise increment cnt.
- Debounce, debounce_en=0: deb <= s2 every edge and cnt is held at 0. Bypass behaves exactly like DEBOUNCE_CYCLES=1.
- Press detect: one-cycle push pulse on a deb 0->1 transition (deb registered vs. its previous value). A release (1->0) does nothing.
- Latency: button sampled high at edge 1 -> deb rises at edge DEBOUNCE_CYCLES+2 -> push at edge DEBOUNCE_CYCLES+3.
  - char_valid is high after that edge when the queue was empty.
  - With bypass, char_valid rises after edge 4.
- Push writes data_btn as sampled at the push edge into mem[wr_ptr] and advances wr_ptr modulo FIFO_DEPTH.
- Pop: occurs on an edge with char_valid && char_ready; advances rd_ptr modulo FIFO_DEPTH. char_ready while empty is ignored.
- char_valid = (fifo_count != 0). char_data = mem[rd_ptr], driven combinationally from registered state. No bubble between back-to-back pops.
- Simultaneous push and pop:
  - Both are performed; count is unchanged.
  - This is allowed even when full, because the pop frees the slot first. Overflow does not set.
- Push while full with no pop: the character is dropped, count stays FIFO_DEPTH, and overflow sets. Overflow clears only on reset.
- Push while empty: char_valid rises the next cycle; there is no combinational bypass from data_btn to char_data.
- Toggling debounce_en mid-count: takes effect on the next edge. Switching to bypass clears cnt.
- Reset released while button is held: s2 reaches 1 after 2 edges. One press is then registered after the normal debounce latency, which is intended.

Decomposition:
- Shared package lcd_pkg holds:
  - LCD_DATA_W = 8
  - default debounce constant LCD_DEBOUNCE_CYCLES = 1024
  - default queue depth LCD_QUEUE_DEPTH = 8
- One natural sub-module, btn_debounce: synchroniser, counter and deb register, producing the press pulse.
- The FIFO stays inline in lcd_char_queue.

Test Plan:
- Reset check: assert reset mid-sim with the queue holding 3 characters -> same cycle, char_valid=0, char_data=0, fifo_count=0, overflow=0.
- Bypass press: debounce_en=0, data_btn=0x41, button held high from edge 1, char_ready=0 -> char_valid=1, char_data=0x41, fifo_count=1 after edge 4; raise char_ready -> fifo_count=0 after the next edge.
- Bounce rejection: DEBOUNCE_CYCLES=4, debounce_en=1; 3-cycle high glitches separated by 2-cycle lows -> no push. Then hold high -> exactly one push, at edge 7 counted from the first stable high sample.
- Overflow: char_ready=0, 9 presses with data 0x30..0x38 -> fifo_count=8, overflow=1. Then drain with char_ready=1 -> char_data sequence 0x30..0x37 on consecutive cycles, and 0x38 never appears.
- Full push+pop: fresh reset, fill to 8, then press while char_ready=1 -> fifo_count stays 8, overflow=0, and the new character appears last.
- Wrap-around: 20 single press/pop cycles -> pointers wrap cleanly, every char_data matches its press order, and fifo_count never exceeds 1.
